// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared button indices and channel state encoding
package btn_conditioner_pkg;

    localparam int NUM_BTN = 5;

    localparam int BTN_L = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } chan_state_t;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - per-button synchroniser, debounce and hold-to-repeat event generator
module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter int CNT_W         = 25,
    parameter int DEB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY  = 30000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic event_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q1;
    logic             sync_q2;
    logic [1:0]       prime_q;
    logic             armed_q;
    logic [CNT_W-1:0] deb_cnt_q;

    chan_state_t      state_q;
    chan_state_t      state_d;
    logic [CNT_W-1:0] rpt_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_d;
    logic             event_d;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prime_q <= 2'b00;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            deb_cnt_q <= '0;
            btn_level <= 1'b0;
        end else if (sync_q2 == btn_level) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            btn_level <= ~btn_level;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + CNT_ONE;
        end
    end

    // A button already down when reset releases must be seen released once
    // (with the synchroniser refilled) before it may generate any event.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            armed_q <= 1'b0;
        end else if (prime_q[1] && !sync_q2 && !btn_level) begin
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        event_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_level && armed_q) begin
                    event_d   = 1'b1;
                    state_d   = ST_HOLD;
                    rpt_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (!btn_level) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end else if (REPEAT_EN && (rpt_cnt_q == DLY_LAST)) begin
                    event_d   = 1'b1;
                    state_d   = ST_REPEAT;
                    rpt_cnt_d = '0;
                end else if (REPEAT_EN) begin
                    rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!btn_level) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == PER_LAST) begin
                    event_d   = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            rpt_cnt_q   <= '0;
            event_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            event_pulse <= event_d;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - five-button conditioner with game-tick aligned command window
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int                   DEB_CYCLES    = 1000000,
    parameter int                   REPEAT_DELAY  = 30000000,
    parameter int                   REPEAT_PERIOD = 10000000,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK   = 5'b01101,
    parameter int                   CNT_W         = 25
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               game_tick,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] cmd,
    output logic               cmd_valid
);

    logic [NUM_BTN-1:0] pending_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .CNT_W         (CNT_W),
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_chan (
            .Clk         (Clk),
            .Reset       (Reset),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .event_pulse (press_pulse[i])
        );
    end

    // An event arriving on the tick itself seeds the next window instead of
    // being dropped; events within one window coalesce into a single command.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pending_q <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
        end else if (game_tick) begin
            cmd       <= pending_q;
            cmd_valid <= |pending_q;
            pending_q <= press_pulse;
        end else begin
            pending_q <= pending_q | press_pulse;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - scoreboard bench for btn_conditioner
module tb_btn_conditioner;

    localparam int             DEB    = 4;
    localparam int             DLY    = 20;
    localparam int             PER    = 8;
    localparam int             TICK   = 16;
    localparam logic [4:0]     RMASK  = 5'b01101;

    typedef struct {
        int c;
        int b;
    } pulse_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] btn_raw;
    logic       game_tick;
    logic [4:0] btn_level;
    logic [4:0] press_pulse;
    logic [4:0] cmd;
    logic       cmd_valid;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         mon_en = 1'b0;

    pulse_t     sb_q[$];
    logic [4:0] exp_ev [int];
    logic [4:0] lvl_chg [int];

    logic [4:0] m_lvl  = '0;
    logic [4:0] m_pend = '0;
    logic [4:0] m_cmd  = '0;
    logic       m_val  = 1'b0;

    btn_conditioner #(
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER),
        .REPEAT_MASK   (RMASK),
        .CNT_W         (25)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .btn_raw     (btn_raw),
        .game_tick   (game_tick),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge Clk);
            #1;
        end
    endtask

    function automatic int align(input int from, input int r);
        int x = from;
        while ((x % TICK) != r) x++;
        return x;
    endfunction

    task automatic add_pulse(input int t, input int b);
        pulse_t p;
        p.c = t;
        p.b = b;
        sb_q.push_back(p);
        if (!exp_ev.exists(t)) exp_ev[t] = '0;
        exp_ev[t] = exp_ev[t] | (5'b00001 << b);
    endtask

    task automatic add_lvl(input int t, input logic [4:0] m);
        if (!lvl_chg.exists(t)) lvl_chg[t] = '0;
        lvl_chg[t] = lvl_chg[t] ^ m;
    endtask

    // Raw press at cycle c held for d cycles: press event 7 cycles later,
    // repeats at +27 then every 8 while the debounced level is still high.
    task automatic hold_start(input logic [4:0] m, input int c, input int d);
        goto(c);
        for (int b = 0; b < 5; b++) begin
            if (m[b]) begin
                add_pulse(c + 3 + DEB, b);
                if (RMASK[b]) begin
                    for (int t = c + 3 + DEB + DLY; t < c + d + 3 + DEB; t += PER)
                        add_pulse(t, b);
                end
            end
        end
        add_lvl(c + 2 + DEB, m);
        add_lvl(c + d + 2 + DEB, m);
        btn_raw = btn_raw | m;
    endtask

    task automatic hold_end(input logic [4:0] m, input int c, input int d);
        goto(c + d);
        btn_raw = btn_raw & ~m;
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            logic [4:0] ev;
            if (lvl_chg.exists(cyc)) m_lvl = m_lvl ^ lvl_chg[cyc];
            check("btn_level", btn_level, m_lvl);
            check("cmd", cmd, m_cmd);
            check("cmd_valid", cmd_valid, m_val);
            while (sb_q.size() > 0 && sb_q[0].c < cyc) begin
                check("pulse_missing", cyc, sb_q[0].c);
                void'(sb_q.pop_front());
            end
            for (int b = 0; b < 5; b++) begin
                if (press_pulse[b]) begin
                    if (sb_q.size() == 0) begin
                        check("pulse_extra", press_pulse, 5'b00000);
                    end else begin
                        pulse_t p;
                        p = sb_q.pop_front();
                        check("pulse_bit", b, p.b);
                        check("pulse_cyc", cyc, p.c);
                    end
                end
            end
            ev = exp_ev.exists(cyc) ? exp_ev[cyc] : 5'b00000;
            if (!Reset) begin
                m_pend = '0;
                m_cmd  = '0;
                m_val  = 1'b0;
            end else if (game_tick) begin
                m_cmd  = m_pend;
                m_val  = |m_pend;
                m_pend = ev;
            end else begin
                m_pend = m_pend | ev;
            end
        end
    end

    initial begin
        game_tick = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            game_tick = ((cyc % TICK) == 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int m;
        Reset   = 1'b0;
        btn_raw = 5'b11111;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_btn_level", btn_level, 5'b00000);
        check("rst_press_pulse", press_pulse, 5'b00000);
        check("rst_cmd", cmd, 5'b00000);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        mon_en = 1'b1;

        // Buttons held through reset: level follows, but no events at all
        Reset = 1'b1;
        add_lvl(cyc + 2 + DEB, 5'b11111);
        goto(cyc + 20);
        add_lvl(cyc + 2 + DEB, 5'b11111);
        btn_raw = 5'b00000;
        goto(cyc + 20);

        // Glitch one cycle shorter than the debounce window
        c = cyc + 2;
        goto(c);
        btn_raw[1] = 1'b1;
        goto(c + DEB - 1);
        btn_raw[1] = 1'b0;
        goto(c + 30);

        // U held long: one press, never repeats
        c = cyc + 2;
        hold_start(5'b00010, c, 100);
        hold_end(5'b00010, c, 100);
        goto(cyc + 40);

        // L held: press, repeat at +20, repeat at +8; both repeats share a
        // tick window and the release lands exactly where a third would fire
        c = align(cyc + 5, 5);
        hold_start(5'b00001, c, 36);
        hold_end(5'b00001, c, 36);
        m = (c + 3 + DEB + DLY) / TICK;
        goto(m * TICK + TICK + 1);
        check("coalesce_cmd0", cmd[0], 1'b1);
        check("coalesce_valid", cmd_valid, 1'b1);
        goto(m * TICK + 2 * TICK + 1);
        check("coalesce_after", cmd_valid, 1'b0);
        goto(cyc + 20);

        // L press event coinciding with game_tick goes to the next window
        c = align(cyc + 5, 9);
        hold_start(5'b00001, c, 8);
        hold_end(5'b00001, c, 8);
        check("tick_cur_win", cmd[0], 1'b0);
        goto(c + 3 + DEB + TICK + 1);
        check("tick_next_win", cmd[0], 1'b1);
        goto(cyc + 30);

        // Simultaneous L, D, R, C are independent
        c = cyc + 3;
        hold_start(5'b11101, c, 12);
        hold_end(5'b11101, c, 12);
        goto(cyc + 50);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
